// File: rtl/deser8_capture.sv
// deser8_capture: reassembles the 8-slot serializer stream into a word.
// Each frame is one start slot (start_in high) followed by WIDTH data
// slots. Completed words go to a valid/ack holding register. Framing
// errors pulse frame_err, and overruns set a sticky flag. Good frames
// are counted.
module deser8_capture #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic             time_025,
    input  logic             start_in,
    input  logic             ser_in,
    input  logic             data_ack,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid,
    output logic             frame_err,
    output logic             overrun,
    output logic [CNT_W-1:0] frame_cnt
);

    localparam int IDX_W = $clog2(WIDTH + 1);

    typedef enum logic {
        HUNT = 1'b0,
        DATA = 1'b1
    } state_t;

    state_t           state, state_next;
    logic [IDX_W-1:0] bit_idx, bit_idx_next;
    logic [WIDTH-1:0] shift, shift_next;
    logic             word_done;
    logic             err_hit;
    logic             acked;

    // An ack only counts while a word is actually being held.
    assign acked = data_ack & data_valid;

    // Next-state logic. Frame progress advances only on sampling ticks.
    always_comb begin
        // NOTE: every signal gets a default before the case statement, so no latch is inferred on paths that skip an assignment.
        state_next   = state;
        bit_idx_next = bit_idx;
        shift_next   = shift;
        word_done    = 1'b0;
        err_hit      = 1'b0;
        if (time_025) begin
            case (state)
                HUNT: begin
                    if (start_in) begin
                        state_next   = DATA;
                        bit_idx_next = IDX_W'(1);
                        shift_next   = '0;
                    end
                end
                DATA: begin
                    if (start_in) begin
                        // An unexpected marker drops the partial word.
                        // Resync on this marker as the new slot 0.
                        err_hit      = 1'b1;
                        bit_idx_next = IDX_W'(1);
                        shift_next   = '0;
                    end else begin
                        for (int k = 0; k < WIDTH; k++) begin
                            if (bit_idx == IDX_W'(k + 1)) shift_next[k] = ser_in;
                        end
                        if (bit_idx == IDX_W'(WIDTH)) begin
                            word_done    = 1'b1;
                            state_next   = HUNT;
                            bit_idx_next = '0;
                        end else begin
                            bit_idx_next = bit_idx + IDX_W'(1);
                        end
                    end
                end
                default: begin
                    state_next   = HUNT;
                    bit_idx_next = '0;
                end
            endcase
        end
    end

    // Frame-tracking registers: state, slot index, and partial word.
    always_ff @(posedge clk_in or negedge reset) begin
        // NOTE: the async reset clears every register, so a partial frame never survives a reset.
        if (!reset) begin
            state   <= HUNT;
            bit_idx <= '0;
            shift   <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments, so every register samples pre-edge values.
            state   <= state_next;
            bit_idx <= bit_idx_next;
            shift   <= shift_next;
        end
    end

    // Holding register, handshake, overrun, error pulse, and frame counter.
    // A completion beats a simultaneous ack.
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            data_out   <= '0;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
            frame_cnt  <= '0;
        end else begin
            frame_err <= err_hit;
            if (word_done) begin
                data_out   <= shift_next;
                data_valid <= 1'b1;
                frame_cnt  <= frame_cnt + CNT_W'(1);
            end else if (acked) begin
                data_valid <= 1'b0;
            end
            if (word_done && data_valid && !data_ack) begin
                overrun <= 1'b1;
            end else if (acked) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_deser8_capture.sv
// Directed bench for deser8_capture. A table of whole frames is applied
// first. Hand-written sequences then cover framing errors, ack corner
// cases, reset mid-frame, and frame counter wrap.
module tb_deser8_capture;

    logic       clk_in = 1'b0;
    logic       reset;
    logic       time_025;
    logic       start_in;
    logic       ser_in;
    logic       data_ack;
    logic [7:0] data_out;
    logic       data_valid;
    logic       frame_err;
    logic       overrun;
    logic [7:0] frame_cnt;

    int n_pass  = 0;
    int n_total = 0;

    deser8_capture #(.WIDTH(8), .CNT_W(8)) dut (
        .clk_in    (clk_in),
        .reset     (reset),
        .time_025  (time_025),
        .start_in  (start_in),
        .ser_in    (ser_in),
        .data_ack  (data_ack),
        .data_out  (data_out),
        .data_valid(data_valid),
        .frame_err (frame_err),
        .overrun   (overrun),
        .frame_cnt (frame_cnt)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        int         hunt_ticks;  // idle ticks with start_in low before the frame
        logic [7:0] word;
        logic       ack_after;   // ack the word after checking it
        logic [7:0] exp_out;
        logic       exp_valid;
        logic       exp_ovr;
        logic [7:0] exp_cnt;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_total++;
        if (actual === expected) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    endtask

    // One tick cycle. Outputs are readable once this returns.
    task automatic tick(input logic st, input logic bit_v, input logic ack);
        @(negedge clk_in);
        time_025 = 1'b1;
        start_in = st;
        ser_in   = bit_v;
        data_ack = ack;
        @(posedge clk_in);
        #1;
        time_025 = 1'b0;
        start_in = 1'b0;
        ser_in   = 1'b0;
        data_ack = 1'b0;
    endtask

    task automatic ack_cycle();
        @(negedge clk_in);
        data_ack = 1'b1;
        @(posedge clk_in);
        #1;
        data_ack = 1'b0;
    endtask

    // Start slot followed by 8 data slots (LSB first). Ack may coincide with the last slot.
    task automatic send_frame(input logic [7:0] w, input logic ack_last);
        logic [7:0] wv;
        wv = w;
        tick(1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 8; k++) tick(1'b0, wv[k], (k == 7) ? ack_last : 1'b0);
    endtask

    initial begin
        reset    = 1'b0;
        time_025 = 1'b0;
        start_in = 1'b0;
        ser_in   = 1'b0;
        data_ack = 1'b0;

        vecs[0] = '{0, 8'hA5, 1'b1, 8'hA5, 1'b1, 1'b0, 8'd1};
        vecs[1] = '{0, 8'h3C, 1'b1, 8'h3C, 1'b1, 1'b0, 8'd2};
        vecs[2] = '{0, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0, 8'd3};
        vecs[3] = '{0, 8'h01, 1'b0, 8'h01, 1'b1, 1'b0, 8'd4};
        vecs[4] = '{0, 8'h02, 1'b1, 8'h02, 1'b1, 1'b1, 8'd5};
        vecs[5] = '{5, 8'h5A, 1'b1, 8'h5A, 1'b1, 1'b0, 8'd6};

        repeat (3) @(posedge clk_in);
        #1;
        check("rst_data_out", data_out, 0);
        check("rst_valid", data_valid, 0);
        check("rst_err", frame_err, 0);
        check("rst_overrun", overrun, 0);
        check("rst_cnt", frame_cnt, 0);
        @(negedge clk_in);
        reset = 1'b1;

        // Table-driven frames.
        for (int i = 0; i < 6; i++) begin
            for (int h = 0; h < vecs[i].hunt_ticks; h++) tick(1'b0, 1'b1, 1'b0);
            if (vecs[i].hunt_ticks > 0) begin
                check($sformatf("v%0d_hunt_valid", i), data_valid, 0);
                check($sformatf("v%0d_hunt_err", i), frame_err, 0);
            end
            send_frame(vecs[i].word, 1'b0);
            check($sformatf("v%0d_data_out", i), data_out, vecs[i].exp_out);
            check($sformatf("v%0d_valid", i), data_valid, vecs[i].exp_valid);
            check($sformatf("v%0d_overrun", i), overrun, vecs[i].exp_ovr);
            check($sformatf("v%0d_cnt", i), frame_cnt, vecs[i].exp_cnt);
            if (vecs[i].ack_after) begin
                ack_cycle();
                check($sformatf("v%0d_ack_valid", i), data_valid, 0);
                check($sformatf("v%0d_ack_overrun", i), overrun, 0);
            end
        end

        // Framing error: marker arrives at slot 4, then a clean 0x81 follows on that marker.
        tick(1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b1, 1'b0);
        tick(1'b0, 1'b1, 1'b0);
        tick(1'b0, 1'b1, 1'b0);
        check("ferr_quiet", frame_err, 0);
        tick(1'b1, 1'b0, 1'b0);
        check("ferr_pulse", frame_err, 1);
        @(posedge clk_in);
        #1;
        check("ferr_one_cycle", frame_err, 0);
        for (int k = 0; k < 8; k++) tick(1'b0, (k == 0 || k == 7), 1'b0);
        check("ferr_data_out", data_out, 8'h81);
        check("ferr_valid", data_valid, 1);
        check("ferr_cnt", frame_cnt, 7);
        ack_cycle();
        check("ferr_ack_valid", data_valid, 0);

        // Ack while nothing is held has no effect.
        ack_cycle();
        check("idle_ack_valid", data_valid, 0);
        check("idle_ack_out", data_out, 8'h81);

        // Completion with a same-edge ack: the new word wins, with no overrun.
        send_frame(8'h11, 1'b0);
        check("sim_first_valid", data_valid, 1);
        send_frame(8'h22, 1'b1);
        check("sim_data_out", data_out, 8'h22);
        check("sim_valid", data_valid, 1);
        check("sim_overrun", overrun, 0);
        check("sim_cnt", frame_cnt, 9);
        ack_cycle();
        check("sim_ack_valid", data_valid, 0);

        // Reset after four data bits clears everything at once.
        send_frame(8'h77, 1'b0);
        tick(1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) tick(1'b0, 1'b1, 1'b0);
        @(negedge clk_in);
        reset = 1'b0;
        #1;
        check("mrst_data_out", data_out, 0);
        check("mrst_valid", data_valid, 0);
        check("mrst_cnt", frame_cnt, 0);
        check("mrst_overrun", overrun, 0);
        @(negedge clk_in);
        reset = 1'b1;
        send_frame(8'hC3, 1'b0);
        check("mrst_c3_out", data_out, 8'hC3);
        check("mrst_c3_valid", data_valid, 1);
        check("mrst_c3_cnt", frame_cnt, 1);
        ack_cycle();

        // Counter wrap: advance to 255, then one more frame wraps to 0.
        for (int i = 0; i < 254; i++) send_frame(8'(i), 1'b1);
        check("wrap_cnt_255", frame_cnt, 255);
        send_frame(8'h9E, 1'b1);
        check("wrap_cnt_0", frame_cnt, 0);
        check("wrap_data_out", data_out, 8'h9E);
        check("wrap_overrun", overrun, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
